// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG TAP / RISC-V debug transport module.
package jtag_dtm_pkg;

  // Standard 4-bit TAP state encoding.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam int unsigned IR_IDCODE = 'h01;
  localparam int unsigned IR_DTMCS  = 'h10;
  localparam int unsigned IR_DMI    = 'h11;
  localparam int unsigned IR_BYPASS = 'h1F;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

  localparam int DTMCS_VERSION_LSB      = 0;
  localparam int DTMCS_VERSION_W        = 4;
  localparam int DTMCS_ABITS_LSB        = 4;
  localparam int DTMCS_ABITS_W          = 6;
  localparam int DTMCS_DMISTAT_LSB      = 10;
  localparam int DTMCS_DMISTAT_W        = 2;
  localparam int DTMCS_IDLE_LSB         = 12;
  localparam int DTMCS_IDLE_W           = 3;
  localparam int DTMCS_DMIRESET_BIT     = 16;
  localparam int DTMCS_DMIHARDRESET_BIT = 17;

  localparam logic [DTMCS_VERSION_W-1:0] DTMCS_VERSION = 4'd1;
  localparam logic [DTMCS_IDLE_W-1:0]    DTMCS_IDLE    = 3'd1;

  function automatic logic [31:0] dtmcs_value(input logic [DTMCS_ABITS_W-1:0] abits,
                                              input logic [DTMCS_DMISTAT_W-1:0] dmistat);
    logic [31:0] v;
    v = '0;
    v[DTMCS_VERSION_LSB +: DTMCS_VERSION_W] = DTMCS_VERSION;
    v[DTMCS_ABITS_LSB +: DTMCS_ABITS_W]     = abits;
    v[DTMCS_DMISTAT_LSB +: DTMCS_DMISTAT_W] = dmistat;
    v[DTMCS_IDLE_LSB +: DTMCS_IDLE_W]       = DTMCS_IDLE;
    return v;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller, advanced on detected TCK rising edges.
module jtag_tap_fsm
  import jtag_dtm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       trst,
  input  logic       tck_rise,
  input  logic       tms,
  output logic [3:0] state
);

  tap_state_e state_reg;

  always_ff @(posedge clk) begin
    if (!reset || trst) begin
      state_reg <= TEST_LOGIC_RESET;
    end else if (tck_rise) begin
      case (state_reg)
        TEST_LOGIC_RESET: state_reg <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_reg <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        state_reg <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state_reg <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         state_reg <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         state_reg <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         state_reg <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         state_reg <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state_reg <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        state_reg <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_reg <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         state_reg <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         state_reg <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         state_reg <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         state_reg <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state_reg <= tms ? SELECT_DR : RUN_TEST_IDLE;
        default:          state_reg <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/jtag_tap_dtm.sv
// JTAG TAP with RISC-V DTM registers (IDCODE, DTMCS, DMI, BYPASS); pins are
// oversampled in clk and DMI updates become valid/ready requests.
module jtag_tap_dtm
  import jtag_dtm_pkg::*;
#(
  parameter int          IR_LEN      = 5,
  parameter logic [31:0] IDCODE_VAL  = 32'h00000001,
  parameter int          ABITS       = 7,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jtag_TCK,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  input  logic             jtag_TRST,
  output logic             jtag_TDO,
  output logic             jtag_TDO_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_resp
);

  localparam int DMI_LEN = ABITS + 34;
  localparam int SHIFT_W = (DMI_LEN > IR_LEN) ? DMI_LEN : IR_LEN;
  localparam int LEN_W   = $clog2(SHIFT_W);

  localparam logic [IR_LEN-1:0] IR_IDCODE_C = IR_LEN'(IR_IDCODE);
  localparam logic [IR_LEN-1:0] IR_DTMCS_C  = IR_LEN'(IR_DTMCS);
  localparam logic [IR_LEN-1:0] IR_DMI_C    = IR_LEN'(IR_DMI);

  // Pin vector: {TRST, TDI, TMS, TCK}; every pin sees the same latency.
  logic [SYNC_STAGES-1:0][3:0] sync_reg, sync_next;
  logic tck_s, tms_s, tdi_s, trst_s, tck_prev_reg, tck_rise, tck_fall;

  assign sync_next[0] = {jtag_TRST, jtag_TDI, jtag_TMS, jtag_TCK};
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) sync_reg <= '0;
    else        sync_reg <= sync_next;
  end

  assign tck_s    = sync_reg[SYNC_STAGES-1][0];
  assign tms_s    = sync_reg[SYNC_STAGES-1][1];
  assign tdi_s    = sync_reg[SYNC_STAGES-1][2];
  assign trst_s   = sync_reg[SYNC_STAGES-1][3];
  assign tck_rise = tck_s & ~tck_prev_reg;
  assign tck_fall = ~tck_s & tck_prev_reg;

  logic [3:0] tap_state_bits;
  tap_state_e tap_state;

  jtag_tap_fsm u_fsm (
    .clk      (clk),
    .reset    (reset),
    .trst     (trst_s),
    .tck_rise (tck_rise),
    .tms      (tms_s),
    .state    (tap_state_bits)
  );
  assign tap_state = tap_state_e'(tap_state_bits);

  logic [IR_LEN-1:0]  ir_reg;
  logic [SHIFT_W-1:0] shift_reg, shift_next, dr_capture;
  logic [LEN_W-1:0]   dr_msb, shift_msb;
  logic               tdo_reg, pending_reg, req_valid_reg, resp_ready_reg;
  logic [1:0]         sticky_reg, dmi_stat, upd_op;
  logic [31:0]        resp_data_reg, req_data_reg;
  logic [ABITS-1:0]   req_addr_reg;
  logic [1:0]         req_op_reg;

  assign dmi_stat = pending_reg ? DMI_RESP_BUSY : sticky_reg;
  assign upd_op   = shift_reg[1:0];

  // TDI always enters at the top of the currently active register length.
  always_comb begin
    dr_msb = LEN_W'(0);
    if (ir_reg == IR_IDCODE_C || ir_reg == IR_DTMCS_C) dr_msb = LEN_W'(31);
    else if (ir_reg == IR_DMI_C)                       dr_msb = LEN_W'(DMI_LEN - 1);
    shift_msb = (tap_state == SHIFT_IR) ? LEN_W'(IR_LEN - 1) : dr_msb;
    shift_next = shift_reg >> 1;
    shift_next[shift_msb] = tdi_s;
  end

  always_comb begin
    dr_capture = '0;
    if (ir_reg == IR_IDCODE_C)     dr_capture[31:0] = IDCODE_VAL;
    else if (ir_reg == IR_DTMCS_C) dr_capture[31:0] = dtmcs_value(DTMCS_ABITS_W'(ABITS), sticky_reg);
    else if (ir_reg == IR_DMI_C)   dr_capture[DMI_LEN-1:0] = {req_addr_reg, resp_data_reg, dmi_stat};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tck_prev_reg   <= 1'b0;
      ir_reg         <= IR_IDCODE_C;
      shift_reg      <= '0;
      tdo_reg        <= 1'b0;
      pending_reg    <= 1'b0;
      sticky_reg     <= '0;
      resp_data_reg  <= '0;
      req_valid_reg  <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_op_reg     <= '0;
      resp_ready_reg <= 1'b0;
    end else begin
      tck_prev_reg <= tck_s;

      if (req_valid_reg && dmi_req_ready) begin
        req_valid_reg  <= 1'b0;
        resp_ready_reg <= 1'b1;
      end
      if (resp_ready_reg && dmi_resp_valid) begin
        resp_ready_reg <= 1'b0;
        pending_reg    <= 1'b0;
        resp_data_reg  <= dmi_resp_data;
        if (sticky_reg == DMI_RESP_OK &&
            (dmi_resp_resp == DMI_RESP_FAILED || dmi_resp_resp == DMI_RESP_BUSY))
          sticky_reg <= dmi_resp_resp;
      end

      // TAP actions come last so a DTMCS hard reset overrides a same-cycle handshake.
      if (trst_s) begin
        ir_reg <= IR_IDCODE_C;
      end else if (tck_rise) begin
        case (tap_state)
          TEST_LOGIC_RESET: ir_reg <= IR_IDCODE_C;
          CAPTURE_IR:       shift_reg <= SHIFT_W'(1);
          CAPTURE_DR: begin
            shift_reg <= dr_capture;
            if (ir_reg == IR_DMI_C && pending_reg) sticky_reg <= DMI_RESP_BUSY;
          end
          SHIFT_IR, SHIFT_DR: shift_reg <= shift_next;
          UPDATE_IR:        ir_reg <= shift_reg[IR_LEN-1:0];
          UPDATE_DR: begin
            if (ir_reg == IR_DTMCS_C) begin
              if (shift_reg[DTMCS_DMIHARDRESET_BIT]) begin
                sticky_reg     <= '0;
                pending_reg    <= 1'b0;
                req_valid_reg  <= 1'b0;
                resp_ready_reg <= 1'b0;
              end else if (shift_reg[DTMCS_DMIRESET_BIT]) begin
                sticky_reg <= '0;
              end
            end else if (ir_reg == IR_DMI_C) begin
              if (pending_reg) begin
                sticky_reg <= DMI_RESP_BUSY;
              end else if (sticky_reg == DMI_RESP_OK &&
                           (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)) begin
                req_valid_reg <= 1'b1;
                pending_reg   <= 1'b1;
                req_op_reg    <= upd_op;
                req_data_reg  <= shift_reg[33:2];
                req_addr_reg  <= shift_reg[ABITS+33:34];
              end
            end
          end
          default: ;
        endcase
      end

      if (tck_fall && (tap_state == SHIFT_IR || tap_state == SHIFT_DR))
        tdo_reg <= shift_reg[0];
    end
  end

  assign jtag_TDO       = tdo_reg;
  assign jtag_TDO_en    = (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
  assign dmi_req_valid  = req_valid_reg;
  assign dmi_req_addr   = req_addr_reg;
  assign dmi_req_data   = req_data_reg;
  assign dmi_req_op     = req_op_reg;
  assign dmi_resp_ready = resp_ready_reg;

endmodule

// File: doc/jtag_tap_dtm.md
Name: jtag_tap_dtm

Overview:
Synthesizable JTAG TAP and RISC-V debug transport module inside the DUT. It consumes the TMS/TCK/TDI/TRST pins driven by the simulation JTAG bridge and returns TDO. Pins are oversampled in the clk domain, TCK edges are detected, and the standard 16-state TAP is run. IR-selected DRs are IDCODE, DTMCS, DMI and BYPASS; DMI updates become valid/ready requests to the debug module.

Parameters:
IR_LEN, 5, instruction register width
IDCODE_VAL, 32'h00000001, value captured by the IDCODE DR; bit0 must be 1
ABITS, 7, DMI address width
SYNC_STAGES, 2, synchronizer depth on all jtag inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
jtag_TCK  in  1  test clock (asynchronous, sampled)
jtag_TMS  in  1  test mode select
jtag_TDI  in  1  test data in
jtag_TRST  in  1  test reset, active-high
jtag_TDO  out  1  test data out
jtag_TDO_en  out  1  high while in Shift-IR or Shift-DR
dmi_req_valid  out  1  DMI request valid
dmi_req_ready  in  1  DMI request accepted
dmi_req_addr  out  ABITS  DMI address
dmi_req_data  out  32  DMI write data
dmi_req_op  out  2  1=read, 2=write
dmi_resp_valid  in  1  DMI response valid
dmi_resp_ready  out  1  DMI response ready
dmi_resp_data  in  32  DMI read data
dmi_resp_resp  in  2  0=ok, 2=failed, 3=busy

Behaviour:
- Reset: reset==0 at a clk edge puts TAP in Test-Logic-Reset and sets IR=5'h01. It clears all outputs, pending flag, sticky status and shift registers to 0. dmi_resp_ready is 0 during reset.
- Sync: TCK/TMS/TDI/TRST each pass through SYNC_STAGES flops. tck_rise = sync TCK & ~prev; tck_fall = ~sync TCK & prev.
- Timing: TCK must stay high and stay low for at least SYNC_STAGES+1 clk cycles each. Faster toggling is unsupported.
- TRST: synced TRST==1 forces Test-Logic-Reset and IR=5'h01, regardless of TCK.
- FSM: on tck_rise, next state follows the IEEE 1149.1 table using synced TMS. TMS=1 for 5 rises reaches Test-Logic-Reset from any state. IR is set to IDCODE on every rise spent in Test-Logic-Reset.
- Actions on tck_rise, keyed by the current state:
  - Capture-IR loads {IR_LEN-2 zeros, 2'b01}.
  - Capture-DR loads the selected DR.
  - Shift-IR and Shift-DR shift right, with TDI entering the MSB of the active length.
  - Update-IR copies the shift register to IR.
  - Update-DR performs the DR side effect.
- TDO: updated on tck_fall to shift[0] when the next state is Shift-IR or Shift-DR. TDO holds its value otherwise.
- IR decode: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (ABITS+34b). 0x1F and all others select BYPASS (1b, captures 0).
- DTMCS capture fields: version[3:0]=1, abits[9:4]=ABITS, dmistat[11:10]=sticky, idle[14:12]=1, all other bits 0.
- DTMCS update: bit16 (dmireset) clears sticky. bit17 (dmihardreset) clears sticky and pending, and drops any req_valid.
- DMI layout: op[1:0], data[33:2], addr[ABITS+33:34].
- DMI capture value: {last_addr, resp_data_q, stat}.
  - stat = 3 if pending, else sticky if sticky≠0, else 0.
  - Capturing while pending sets sticky=3.
- DMI update:
  - If op∈{1,2}, sticky==0 and not pending: latch addr/data/op and assert dmi_req_valid.
  - If pending: set sticky=3 and issue nothing.
  - op 0 and op 3 are ignored.
- DMI request handshake: valid holds with stable payload until ready. The request completes in the cycle valid&ready=1, after which valid is deasserted.
- DMI response handshake: dmi_resp_ready=1 while waiting for a response. On valid&ready, latch resp_data_q and clear pending. resp 2 or 3 sets sticky to that value if sticky==0.
- pending is set when the request is issued and cleared at the response. It covers both the request phase and the response wait.
- Reset mid-shift or mid-transaction aborts everything. Late dmi_resp_valid after reset is ignored, since ready=0.

Decomposition:
- Package jtag_dtm_pkg holds:
  - tap_state_e, the 16 states in 4-bit standard encoding
  - IR opcode constants
  - DMI op and resp codes
  - DTMCS field offsets and widths
- Sub-module jtag_tap_fsm holds the state register and next-state table. Its inputs are clk, reset, trst, tck_rise and tms; its output is state.

Test Plan:
- Hold TRST high, then 5×TMS=1, then shift DR → 32 TDO bits equal 32'h00000001. IR read at Capture-IR yields 5'b00001.
- Load IR=0x1F and shift 8 bits 0xA5 through DR → TDO shows the same bits delayed by exactly one TCK.
- Load IR=0x10 and read DTMCS → 0x00001071 with ABITS=7, sticky=0.
- DMI write addr 0x10, data 0xDEADBEEF, op=2 → one req beat with those fields. Bench responds resp=0. A following op=1 read of 0x10 with response 0x12345678 → next capture shows data 0x12345678 and op 0.
- Hold dmi_req_ready=0 and issue a second DMI update → no second request, capture stat=3. Write DTMCS bit16, release ready → capture stat 0.
- Assert reset low during Shift-DR with req_valid=1 → req_valid=0 next clk, TAP in Test-Logic-Reset, IR=0x01.
